// File: rtl/gemm_output_manager.sv
// Collects the four PE results of a 2x2 GEMM tile and drains them downstream as two rows with ready/valid.
// Optional GEMM_OUT_SATURATE_EN: signed saturation instead of truncation when narrowing elements.
module gemm_output_manager #(
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*ACC_WIDTH-1:0] mac_acc,
    input  logic [3:0]             mac_done,
    output logic                   mac_clear,
    output logic [2*OUT_WIDTH-1:0] out_row,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overrun,
    output logic [7:0]             tile_count
);

    localparam int unsigned N_PE    = 4;
    localparam int unsigned UPPER_W = ACC_WIDTH - OUT_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN0  = 2'd2,
        DRAIN1  = 2'd3
    } state_t;

    state_t                             state, state_nxt;
    logic [N_PE-1:0]                    captured, captured_nxt;
    logic [N_PE-1:0][OUT_WIDTH-1:0]     res, res_nxt;
    logic [N_PE-1:0]                    accept;
    logic                               mac_clear_nxt;
    logic [2*OUT_WIDTH-1:0]             out_row_nxt;
    logic                               out_valid_nxt;
    logic                               out_last_nxt;
    logic                               busy_nxt;
    logic                               overrun_nxt;
    logic [7:0]                         tile_count_nxt;

    // Narrow one accumulator to an output element.
    function automatic logic [OUT_WIDTH-1:0] convert(input logic [ACC_WIDTH-1:0] acc);
`ifdef GEMM_OUT_SATURATE_EN
        logic [UPPER_W-1:0] upper;
        upper = acc[ACC_WIDTH-1:OUT_WIDTH-1];
        if ((upper == '0) || (upper == '1)) begin
            return acc[OUT_WIDTH-1:0];
        end else if (acc[ACC_WIDTH-1]) begin
            return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
`else
        return OUT_WIDTH'(acc);
`endif
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            captured   <= '0;
            res        <= '0;
            mac_clear  <= 1'b0;
            out_row    <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            tile_count <= 8'd0;
        end else begin
            state      <= state_nxt;
            captured   <= captured_nxt;
            res        <= res_nxt;
            mac_clear  <= mac_clear_nxt;
            out_row    <= out_row_nxt;
            out_valid  <= out_valid_nxt;
            out_last   <= out_last_nxt;
            busy       <= busy_nxt;
            overrun    <= overrun_nxt;
            tile_count <= tile_count_nxt;
        end
    end

    // Next state and next values of every registered output; the first row is
    // loaded on the capture edge so out_valid rises one edge after the last done.
    always_comb begin
        state_nxt      = state;
        captured_nxt   = captured;
        res_nxt        = res;
        accept         = '0;
        mac_clear_nxt  = 1'b0;
        out_row_nxt    = out_row;
        out_valid_nxt  = out_valid;
        out_last_nxt   = out_last;
        overrun_nxt    = overrun;
        tile_count_nxt = tile_count;

        case (state)
            IDLE, COLLECT: begin
                accept = mac_done & ~captured;
                if (|(mac_done & captured)) begin
                    overrun_nxt = 1'b1;
                end
                for (int i = 0; i < N_PE; i++) begin
                    if (accept[i]) begin
                        res_nxt[i] = convert(mac_acc[i*ACC_WIDTH +: ACC_WIDTH]);
                    end
                end
                captured_nxt = captured | accept;
                if (&captured_nxt) begin
                    state_nxt     = DRAIN0;
                    captured_nxt  = '0;
                    mac_clear_nxt = 1'b1;
                    out_valid_nxt = 1'b1;
                    out_row_nxt   = {res_nxt[1], res_nxt[0]};
                    out_last_nxt  = 1'b0;
                end else if (|captured_nxt) begin
                    state_nxt = COLLECT;
                end
            end
            DRAIN0: begin
                if (|mac_done) begin
                    overrun_nxt = 1'b1;
                end
                if (out_valid && out_ready) begin
                    state_nxt    = DRAIN1;
                    out_row_nxt  = {res[3], res[2]};
                    out_last_nxt = 1'b1;
                end
            end
            DRAIN1: begin
                if (|mac_done) begin
                    overrun_nxt = 1'b1;
                end
                if (out_valid && out_ready) begin
                    state_nxt      = IDLE;
                    out_valid_nxt  = 1'b0;
                    out_last_nxt   = 1'b0;
                    tile_count_nxt = tile_count + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt == DRAIN0) || (state_nxt == DRAIN1);
    end

endmodule

// File: tb/tb_gemm_output_manager.sv
// Self-checking bench for gemm_output_manager: table-driven tiles, scoreboard of expected rows, corner sequences.
module tb_gemm_output_manager;

    logic             clk = 1'b0;
    logic             reset;
    logic [127:0]     mac_acc;
    logic [3:0]       mac_done;
    logic             mac_clear;
    logic [31:0]      out_row;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             overrun;
    logic [7:0]       tile_count;

    typedef struct packed {
        logic [15:0] c1;
        logic [15:0] c0;
        logic        last;
    } row_t;

    typedef struct {
        logic [3:0][31:0] v;
        bit               simul;
        logic [15:0]      e00, e01, e10, e11;
    } vec_t;

    row_t exp_q[$];
    vec_t tbl[4];
    int   n_cmp  = 0;
    int   n_fail = 0;

    gemm_output_manager #(.ACC_WIDTH(32), .OUT_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .mac_acc    (mac_acc),
        .mac_done   (mac_done),
        .mac_clear  (mac_clear),
        .out_row    (out_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .overrun    (overrun),
        .tile_count (tile_count)
    );

    always #5 clk = ~clk;

    // Reference narrowing, written as a signed range check.
    function automatic logic [15:0] conv(input logic [31:0] a);
`ifdef GEMM_OUT_SATURATE_EN
        if ($signed(a) > 32767) return 16'h7fff;
        else if ($signed(a) < -32768) return 16'h8000;
        else return a[15:0];
`else
        return a[15:0];
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted row is checked against the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_row", out_row, 32'hxxxx_xxxx);
            end else begin
                row_t e;
                e = exp_q.pop_front();
                chk("row_data", out_row, {e.c1, e.c0});
                chk("row_last", {31'd0, out_last}, {31'd0, e.last});
            end
        end
    end

    task automatic push_rows(input logic [15:0] e00, e01, e10, e11);
        exp_q.push_back('{c1: e01, c0: e00, last: 1'b0});
        exp_q.push_back('{c1: e11, c0: e10, last: 1'b1});
    endtask

    // Leaves the DUT in DRAIN0 (state after the final done edge).
    task automatic drive_tile(input logic [3:0][31:0] v, input bit simul);
        mac_acc = v;
        if (simul) begin
            mac_done = 4'hf;
            tick();
        end else begin
            for (int k = 0; k < 4; k++) begin
                mac_done = 4'(1 << k);
                tick();
            end
        end
        mac_done = 4'h0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && (busy || out_valid); k++) tick();
        chk("drain_done", {30'd0, busy, out_valid}, 32'd0);
    endtask

    task automatic random_tile();
        logic [3:0][31:0] v;
        for (int k = 0; k < 4; k++) v[k] = $urandom;
        push_rows(conv(v[0]), conv(v[1]), conv(v[2]), conv(v[3]));
        drive_tile(v, 1'b1);
        wait_idle();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_last"}, {31'd0, out_last}, 32'd0);
        chk({tag, "_row"}, out_row, 32'd0);
        chk({tag, "_clear"}, {31'd0, mac_clear}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        chk({tag, "_tiles"}, {24'd0, tile_count}, 32'd0);
    endtask

    initial begin
        logic [3:0][31:0] v;

        tbl[0] = '{v: {32'd4, 32'd3, 32'd2, 32'd1}, simul: 1'b0,
                   e00: 16'd1, e01: 16'd2, e10: 16'd3, e11: 16'd4};
        tbl[1] = '{v: {32'hffff_8000, 32'h0000_7fff, 32'hffff_ffff, 32'h0000_1234}, simul: 1'b1,
                   e00: 16'h1234, e01: 16'hffff, e10: 16'h7fff, e11: 16'h8000};
`ifdef GEMM_OUT_SATURATE_EN
        tbl[2] = '{v: {32'hffff_7fff, 32'h0000_7fff, 32'hfffe_0000, 32'h0001_0000}, simul: 1'b1,
                   e00: 16'h7fff, e01: 16'h8000, e10: 16'h7fff, e11: 16'h8000};
        tbl[3] = '{v: {32'h7fff_ffff, 32'h8000_0000, 32'd5, 32'hdead_beef}, simul: 1'b0,
                   e00: 16'h8000, e01: 16'h0005, e10: 16'h8000, e11: 16'h7fff};
`else
        tbl[2] = '{v: {32'hffff_7fff, 32'h0000_7fff, 32'hfffe_0000, 32'h0001_0000}, simul: 1'b1,
                   e00: 16'h0000, e01: 16'h0000, e10: 16'h7fff, e11: 16'h7fff};
        tbl[3] = '{v: {32'h7fff_ffff, 32'h8000_0000, 32'd5, 32'hdead_beef}, simul: 1'b0,
                   e00: 16'hbeef, e01: 16'h0005, e10: 16'h0000, e11: 16'hffff};
`endif

        reset = 1'b1; mac_acc = '0; mac_done = 4'h0; out_ready = 1'b1;
        #1;
        check_zero_outputs("reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        tick();

        // Table-driven tiles with the sink always ready
        for (int t = 0; t < 4; t++) begin
            push_rows(tbl[t].e00, tbl[t].e01, tbl[t].e10, tbl[t].e11);
            drive_tile(tbl[t].v, tbl[t].simul);
            wait_idle();
        end
        chk("table_tiles", {24'd0, tile_count}, 32'd4);
        chk("table_overrun", {31'd0, overrun}, 32'd0);
        chk("table_queue_empty", exp_q.size(), 32'd0);

        // All four done at once: latency, single mac_clear pulse, back-to-back rows
        v = {32'd40, 32'd30, 32'd20, 32'd10};
        push_rows(16'd10, 16'd20, 16'd30, 16'd40);
        mac_acc = v; mac_done = 4'hf;
        @(negedge clk);
        chk("lat_no_comb_valid", {31'd0, out_valid}, 32'd0);
        tick();
        mac_done = 4'h0;
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_clear", {31'd0, mac_clear}, 32'd1);
        chk("lat_busy", {31'd0, busy}, 32'd1);
        chk("lat_last0", {31'd0, out_last}, 32'd0);
        tick();
        chk("lat_clear_once", {31'd0, mac_clear}, 32'd0);
        chk("lat_row1_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_row1_last", {31'd0, out_last}, 32'd1);
        tick();
        chk("lat_done_valid", {31'd0, out_valid}, 32'd0);
        chk("lat_tiles", {24'd0, tile_count}, 32'd5);
        chk("lat_overrun", {31'd0, overrun}, 32'd0);

        // Backpressure in DRAIN0
        out_ready = 1'b0;
        push_rows(16'h0aaa, 16'h0bbb, 16'h0ccc, 16'h0ddd);
        drive_tile({32'h0ddd, 32'h0ccc, 32'h0bbb, 32'h0aaa}, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            chk("bp_row", out_row, 32'h0bbb_0aaa);
            chk("bp_last", {31'd0, out_last}, 32'd0);
        end
        tick();
        out_ready = 1'b1;
        tick();
        chk("bp_row1_next_cycle", {30'd0, out_valid, out_last}, 32'd3);
        tick();
        chk("bp_done", {30'd0, busy, out_valid}, 32'd0);
        chk("bp_queue_empty", exp_q.size(), 32'd0);

        // Duplicate done for PE0 keeps the first value and sets overrun
        push_rows(16'd7, 16'd2, 16'd3, 16'd4);
        mac_acc = '0;
        mac_acc[31:0] = 32'd7; mac_done = 4'b0001; tick();
        mac_acc[31:0] = 32'd9; mac_done = 4'b0001; tick();
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        mac_acc = {32'd4, 32'd3, 32'd2, 32'd9};
        mac_done = 4'b0010; tick();
        mac_done = 4'b0100; tick();
        mac_done = 4'b1000; tick();
        mac_done = 4'h0;
        wait_idle();
        random_tile();
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-drain with tile_count at 255, then wrap after 256 tiles
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        tick();
        chk("rst_overrun_clear", {31'd0, overrun}, 32'd0);
        for (int t = 0; t < 255; t++) random_tile();
        chk("tiles_255", {24'd0, tile_count}, 32'd255);
        out_ready = 1'b0;
        push_rows(16'd1, 16'd2, 16'd3, 16'd4);
        drive_tile({32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("mid_in_drain1", {30'd0, busy, out_last}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check_zero_outputs("mid_reset");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        random_tile();
        chk("tiles_after_reset", {24'd0, tile_count}, 32'd1);
        for (int t = 0; t < 255; t++) random_tile();
        chk("tiles_wrap", {24'd0, tile_count}, 32'd0);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
